// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } op_t;

    // Read data handed back when the watchdog aborts an access.
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU-side request/done signals and the single memory port, bundled.
// Latency: none (wiring only).
// Backpressure: mem_ready stalls the arbiter; cpu_stall holds the CPU.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch path
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    // Load/store path
    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    // Memory port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    // Status
    logic              cpu_stall;
    logic              err_timeout;

    // Arbiter view
    modport slave (
        input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_ready, mem_rdata,
        output if_done, if_rdata, d_done, d_rdata, mem_addr, mem_wdata, mem_rd, mem_wr,
               cpu_stall, err_timeout
    );

    // CPU + memory view
    modport master (
        output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_ready, mem_rdata,
        input  if_done, if_rdata, d_done, d_rdata, mem_addr, mem_wdata, mem_rd, mem_wr,
               cpu_stall, err_timeout
    );

endinterface

// File: rtl/mem_port_arbiter_arb2_rr.sv
// Two-way round-robin pick; gnt_sel=1 selects requester 1.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module arb2_rr (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_sel
);

    // Requester 1 wins when alone, or on a tie when requester 0 won last time.
    always_comb begin
        gnt_sel = 1'b0;
        if (req1 && (!req0 || !last)) begin
            gnt_sel = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Latency: grant edge -> BUSY (>=1 cycle, until mem_ready or watchdog) -> 1-cycle DONE pulse.
// Backpressure: mem_ready extends BUSY; cpu_stall holds the CPU until its done pulse.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                WAIT_MAX = 15,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus
);

    localparam int                CNT_W     = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    owner_t            r_owner;
    owner_t            r_last_grant;
    owner_t            w_gnt_owner;
    op_t               r_op;
    op_t               w_gnt_op;
    logic [ADDR_W-1:0] r_addr_q;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] r_wdata_q;
    logic [DATA_W-1:0] r_rdata_q;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_err_timeout;

    logic w_f_pend;
    logic w_d_pend;
    logic w_gnt_sel;
    logic w_grant;
    logic w_timeout;
    logic w_busy;
    logic w_done;
    logic w_if_done;
    logic w_d_done;

    assign w_f_pend = bus.if_req;
    assign w_d_pend = bus.d_rd | bus.d_wr;

    arb2_rr u_arb (
        .req0    (w_f_pend),
        .req1    (w_d_pend),
        .last    (r_last_grant == DATA),
        .gnt_sel (w_gnt_sel)
    );

    // Winner's owner, operation and address; a store wins over a load if both are raised.
    always_comb begin
        w_gnt_owner = w_gnt_sel ? DATA : FETCH;
        w_gnt_op    = RD;
        w_gnt_addr  = bus.if_addr;
        if (w_gnt_owner == DATA) begin
            w_gnt_addr = bus.d_addr;
            if (bus.d_wr) begin
                w_gnt_op = WR;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus grant/abort events; DONE always returns to IDLE so requesters can retire.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_f_pend || w_d_pend) begin
                    w_grant     = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    w_state_nxt = DONE;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Access context latched at grant, watchdog count, read data capture and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner       <= FETCH;
            r_op          <= RD;
            r_addr_q      <= '0;
            r_wdata_q     <= '0;
            r_last_grant  <= FETCH;
            r_wait_cnt    <= '0;
            r_rdata_q     <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_grant) begin
                r_owner      <= w_gnt_owner;
                r_op         <= w_gnt_op;
                r_addr_q     <= w_gnt_addr;
                r_wdata_q    <= (w_gnt_owner == DATA) ? bus.d_wdata : '0;
                r_last_grant <= w_gnt_owner;
                r_wait_cnt   <= '0;
            end
            if (r_state == BUSY) begin
                if (bus.mem_ready) begin
                    if (r_op == RD) begin
                        r_rdata_q <= bus.mem_rdata;
                    end
                end else if (w_timeout) begin
                    r_rdata_q     <= ERR_DATA;
                    r_err_timeout <= 1'b1;
                end else begin
                    r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Outputs decode only from registers, so reset clears them without waiting for an edge.
    assign w_busy    = (r_state == BUSY);
    assign w_done    = (r_state == DONE);
    assign w_if_done = w_done & (r_owner == FETCH);
    assign w_d_done  = w_done & (r_owner == DATA);

    assign bus.mem_addr    = w_busy ? r_addr_q  : '0;
    assign bus.mem_wdata   = w_busy ? r_wdata_q : '0;
    assign bus.mem_rd      = w_busy & (r_op == RD);
    assign bus.mem_wr      = w_busy & (r_op == WR);
    assign bus.if_done     = w_if_done;
    assign bus.d_done      = w_d_done;
    assign bus.if_rdata    = w_if_done ? r_rdata_q : '0;
    assign bus.d_rdata     = w_d_done  ? r_rdata_q : '0;
    assign bus.err_timeout = r_err_timeout;
    assign bus.cpu_stall   = (bus.if_req & ~w_if_done) | ((bus.d_rd | bus.d_wr) & ~w_d_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed protocol cases, then random fetch/data traffic against a memory model.
// Latency: checks the 3-cycle access and the 15-cycle watchdog abort.
// Backpressure: the memory model inserts a per-access number of wait cycles.
module tb_mem_port_arbiter;

    localparam logic [31:0] DBASE = 32'h0000_0100;
    localparam logic [31:0] ERRW  = 32'hDEADBEEF;

    typedef struct {
        logic [31:0] rdata;
        bit          chk_data;
        bit          to;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   f_plan;
    int   d_plan;
    exp_t fq[$];
    exp_t dq[$];
    logic [31:0] mem_arr [16];
    logic [31:0] dref    [16];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .WAIT_MAX (15),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: fixed word at 0x40, a hash elsewhere.
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C220004;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // Wait-cycle plan for one access; >=15 means memory never answers.
    function automatic int pick_plan();
        int tbl [11] = '{0, 0, 0, 1, 2, 3, 5, 13, 14, 15, 20};
        return tbl[$urandom_range(0, 10)];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, required %b at %0t", name, act, exp, $time);
        end
    endtask

    // Wait (bounded) for the requester's done pulse, then step to just after the DONE edge.
    task automatic wait_done(input bit is_data);
        int t   = 0;
        bit got = 0;
        while (!got && t < 200) begin
            @(negedge clk);
            t++;
            got = is_data ? bus.d_done : bus.if_done;
        end
        chk1(is_data ? "d_done_arrives" : "if_done_arrives", got, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_access(input logic [31:0] a, input int p);
        exp_t e;
        f_plan     = p;
        e.to       = (p >= 15);
        e.chk_data = 1'b1;
        e.rdata    = e.to ? ERRW : rom(a);
        fq.push_back(e);
        bus.if_addr = a;
        bus.if_req  = 1'b1;
        wait_done(1'b0);
        bus.if_req  = 1'b0;
    endtask

    // kind: 0 load, 1 store, 2 load+store raised together (behaves as store)
    task automatic data_access(input int kind, input int idx, input logic [31:0] wd, input int p);
        exp_t e;
        d_plan = p;
        e.to   = (p >= 15);
        if (kind == 0) begin
            e.chk_data = 1'b1;
            e.rdata    = e.to ? ERRW : dref[idx];
        end else begin
            e.chk_data = e.to;
            e.rdata    = ERRW;
            if (!e.to) dref[idx] = wd;
        end
        dq.push_back(e);
        bus.d_addr  = DBASE + 32'(idx * 4);
        bus.d_wdata = wd;
        bus.d_rd    = (kind != 1);
        bus.d_wr    = (kind != 0);
        wait_done(1'b1);
        bus.d_rd    = 1'b0;
        bus.d_wr    = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_fetch(input int n);
        for (int k = 0; k < n; k++) begin
            gap();
            fetch_access(32'($urandom_range(0, 63)) << 2, pick_plan());
        end
    endtask

    task automatic run_data(input int n);
        for (int k = 0; k < n; k++) begin
            gap();
            data_access($urandom_range(0, 2), $urandom_range(0, 15), $urandom, pick_plan());
        end
    endtask

    // Memory model: answers after the planned number of BUSY cycles, noise on mem_ready otherwise.
    initial begin : mem_model
        int bc;
        int plan;
        int idx;
        bc = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_rd || bus.mem_wr) begin
                plan = (bus.mem_addr >= DBASE) ? d_plan : f_plan;
                if (bc == plan) begin
                    bus.mem_ready = 1'b1;
                    if (bus.mem_addr >= DBASE) begin
                        idx = int'((bus.mem_addr - DBASE) >> 2) & 15;
                        if (bus.mem_wr) mem_arr[idx] = bus.mem_wdata;
                        bus.mem_rdata = mem_arr[idx];
                    end else begin
                        bus.mem_rdata = rom(bus.mem_addr);
                    end
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = $urandom;
                end
                bc++;
            end else begin
                bc = 0;
                bus.mem_ready = 1'($urandom);
                bus.mem_rdata = $urandom;
            end
        end
    end

    // Scoreboard monitor: every done pulse pops and checks the requester's expected response.
    initial begin : monitor
        bit   seen_to;
        exp_t e;
        seen_to = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) seen_to = 1'b0;
            chk1("single_done", bus.if_done & bus.d_done, 1'b0);
            if (bus.if_done) begin
                chk1("if_done_expected", fq.size() > 0, 1'b1);
                if (fq.size() > 0) begin
                    e = fq.pop_front();
                    if (e.to) seen_to = 1'b1;
                    chk("if_rdata", bus.if_rdata, e.rdata);
                    chk1("err_timeout_at_if_done", bus.err_timeout, seen_to);
                end
            end else begin
                chk("if_rdata_idle_zero", bus.if_rdata, 32'h0);
            end
            if (bus.d_done) begin
                chk1("d_done_expected", dq.size() > 0, 1'b1);
                if (dq.size() > 0) begin
                    e = dq.pop_front();
                    if (e.to) seen_to = 1'b1;
                    if (e.chk_data) chk("d_rdata", bus.d_rdata, e.rdata);
                    chk1("err_timeout_at_d_done", bus.err_timeout, seen_to);
                end
            end else begin
                chk("d_rdata_idle_zero", bus.d_rdata, 32'h0);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL global_watchdog: simulation still running at %0t, required to finish", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   cnt;
        exp_t e;
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) begin
            mem_arr[i] = 32'hA500_0000 + 32'(i);
            dref[i]    = 32'hA500_0000 + 32'(i);
        end
        f_plan      = 0;
        d_plan      = 0;
        rst_n       = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h40;
        bus.d_rd    = 1'b0;
        bus.d_wr    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        // Reset held 3 cycles with a fetch pending.
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_mem_rd", bus.mem_rd, 1'b0);
        chk1("rst_mem_wr", bus.mem_wr, 1'b0);
        chk1("rst_if_done", bus.if_done, 1'b0);
        chk1("rst_d_done", bus.d_done, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        chk1("rst_err_timeout", bus.err_timeout, 1'b0);
        chk1("rst_cpu_stall", bus.cpu_stall, 1'b1);

        // Simple fetch at 0x40, memory ready immediately.
        e.rdata = 32'h8C220004; e.chk_data = 1'b1; e.to = 1'b0;
        fq.push_back(e);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk1("fetch_c1_mem_rd", bus.mem_rd, 1'b1);
        chk1("fetch_c1_mem_wr", bus.mem_wr, 1'b0);
        chk("fetch_c1_mem_addr", bus.mem_addr, 32'h40);
        chk1("fetch_c1_stall", bus.cpu_stall, 1'b1);
        @(posedge clk); #1;
        chk1("fetch_c2_if_done", bus.if_done, 1'b1);
        chk("fetch_c2_if_rdata", bus.if_rdata, 32'h8C220004);
        chk1("fetch_c2_stall", bus.cpu_stall, 1'b0);
        chk1("fetch_c2_mem_rd", bus.mem_rd, 1'b0);
        @(posedge clk); #1;
        bus.if_req = 1'b0;

        // Reset during the second BUSY cycle: strobe drops without a clock edge, no done pulse.
        f_plan      = 99;
        bus.if_addr = 32'h44;
        bus.if_req  = 1'b1;
        @(posedge clk); #1;
        chk1("midrst_busy1_mem_rd", bus.mem_rd, 1'b1);
        @(posedge clk); #1;
        chk1("midrst_busy2_mem_rd", bus.mem_rd, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("midrst_async_mem_rd", bus.mem_rd, 1'b0);
        chk("midrst_async_mem_addr", bus.mem_addr, 32'h0);
        bus.if_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk1("midrst_idle_mem_rd", bus.mem_rd, 1'b0);
            chk1("midrst_no_if_done", bus.if_done, 1'b0);
        end

        // Tie from reset: DATA, FETCH, DATA, FETCH.
        f_plan = 0;
        d_plan = 0;
        for (int k = 0; k < 2; k++) begin
            e.rdata = rom(32'h80); e.chk_data = 1'b1; e.to = 1'b0;
            fq.push_back(e);
            e.rdata = dref[1];
            dq.push_back(e);
        end
        bus.if_addr = 32'h80;
        bus.d_addr  = 32'h104;
        bus.if_req  = 1'b1;
        bus.d_rd    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("rr_grant_addr", bus.mem_addr, (k % 2 == 0) ? 32'h104 : 32'h80);
            chk1("rr_grant_mem_rd", bus.mem_rd, 1'b1);
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        bus.if_req = 1'b0;
        bus.d_rd   = 1'b0;

        // Store with three wait cycles: strobes and bus held stable for four BUSY cycles.
        d_plan = 3;
        e.rdata = ERRW; e.chk_data = 1'b0; e.to = 1'b0;
        dq.push_back(e);
        dref[0]     = 32'h1234;
        bus.d_addr  = 32'h100;
        bus.d_wdata = 32'h1234;
        bus.d_wr    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk1("store_mem_wr", bus.mem_wr, 1'b1);
            chk1("store_mem_rd", bus.mem_rd, 1'b0);
            chk("store_mem_addr", bus.mem_addr, 32'h100);
            chk("store_mem_wdata", bus.mem_wdata, 32'h1234);
        end
        @(posedge clk); #1;
        chk1("store_d_done", bus.d_done, 1'b1);
        chk1("store_if_done", bus.if_done, 1'b0);
        chk1("store_done_stall", bus.cpu_stall, 1'b0);
        @(posedge clk); #1;
        chk1("store_d_done_once", bus.d_done, 1'b0);
        bus.d_wr = 1'b0;

        // Watchdog: memory never answers a load.
        d_plan = 99;
        e.rdata = ERRW; e.chk_data = 1'b1; e.to = 1'b1;
        dq.push_back(e);
        bus.d_addr = 32'h108;
        bus.d_rd   = 1'b1;
        cnt = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (bus.d_done) break;
            if (bus.mem_rd) cnt++;
        end
        chk("timeout_busy_cycles", 32'(cnt), 32'd15);
        chk1("timeout_d_done", bus.d_done, 1'b1);
        chk("timeout_d_rdata", bus.d_rdata, ERRW);
        chk1("timeout_err", bus.err_timeout, 1'b1);
        @(posedge clk); #1;
        bus.d_rd = 1'b0;

        // Later successful accesses leave the error flag set; the store is read back.
        data_access(0, 0, 32'h0, 0);
        fetch_access(32'hC0, 2);
        chk1("err_sticky", bus.err_timeout, 1'b1);

        // Random concurrent traffic.
        fork
            run_fetch(40);
            run_data(40);
        join

        repeat (5) @(posedge clk);
        #1;
        chk("fetch_queue_drained", 32'(fq.size()), 32'h0);
        chk("data_queue_drained", 32'(dq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
